// File: rtl/tmr_scrub_if.sv
// Bus bundle for the self-scrubbing triplicated register: per-channel write
// ports, voted read-back and the SEU monitoring outputs.
interface tmr_scrub_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     dinA;
  logic [WIDTH-1:0]     dinB;
  logic [WIDTH-1:0]     dinC;
  logic                 loadA;
  logic                 loadB;
  logic                 loadC;
  logic                 clearCnt;
  logic [WIDTH-1:0]     doutA;
  logic [WIDTH-1:0]     doutB;
  logic [WIDTH-1:0]     doutC;
  logic                 errA;
  logic                 errB;
  logic                 errC;
  logic                 tmrErr;
  logic                 multiErr;
  logic [CNT_WIDTH-1:0] errCntA;
  logic [CNT_WIDTH-1:0] errCntB;
  logic [CNT_WIDTH-1:0] errCntC;

  modport master (
    output dinA, dinB, dinC, loadA, loadB, loadC, clearCnt,
    input  doutA, doutB, doutC, errA, errB, errC, tmrErr, multiErr,
    input  errCntA, errCntB, errCntC
  );

  modport slave (
    input  dinA, dinB, dinC, loadA, loadB, loadC, clearCnt,
    output doutA, doutB, doutC, errA, errB, errC, tmrErr, multiErr,
    output errCntA, errCntB, errCntC
  );
endinterface

// File: rtl/tmr_scrub_register.sv
// Triplicated register with per-output voters, continuous scrubbing from the
// vote, registered mismatch flags and saturating per-channel error counters.
module tmr_scrub_register #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        rstn,
  tmr_scrub_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Bitwise 2-of-3 majority.
  function automatic logic [WIDTH-1:0] maj3(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Saturating counter update; clear takes priority over an increment.
  function automatic logic [CNT_WIDTH-1:0] nextCnt(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 hit,
    input logic                 clr
  );
    logic [CNT_WIDTH-1:0] res;
    if (clr) begin
      res = CNT_ZERO;
    end else if (hit && (cnt != CNT_MAX)) begin
      res = cnt + CNT_ONE;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic [WIDTH-1:0]     regA_r;
  logic [WIDTH-1:0]     regB_r;
  logic [WIDTH-1:0]     regC_r;
  logic [WIDTH-1:0]     voteA_s;
  logic [WIDTH-1:0]     voteB_s;
  logic [WIDTH-1:0]     voteC_s;
  logic                 mmA_s;
  logic                 mmB_s;
  logic                 mmC_s;
  logic                 anyMm_s;
  logic                 multiMm_s;
  logic                 errA_r;
  logic                 errB_r;
  logic                 errC_r;
  logic                 tmrErr_r;
  logic                 multiErr_r;
  logic [CNT_WIDTH-1:0] cntA_r;
  logic [CNT_WIDTH-1:0] cntB_r;
  logic [CNT_WIDTH-1:0] cntC_r;

  // Three independent voters, one per output channel; each channel is checked
  // against its own voter so a voter fault stays confined to one channel.
  always_comb begin
    voteA_s   = maj3(regA_r, regB_r, regC_r);
    voteB_s   = maj3(regA_r, regB_r, regC_r);
    voteC_s   = maj3(regA_r, regB_r, regC_r);
    mmA_s     = (regA_r != voteA_s);
    mmB_s     = (regB_r != voteB_s);
    mmC_s     = (regC_r != voteC_s);
    anyMm_s   = mmA_s | mmB_s | mmC_s;
    multiMm_s = (mmA_s & mmB_s) | (mmA_s & mmC_s) | (mmB_s & mmC_s);
  end

  // Channel storage: load wins, otherwise refresh from the vote every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regA_r <= RESET_VALUE;
      regB_r <= RESET_VALUE;
      regC_r <= RESET_VALUE;
    end else begin
      regA_r <= bus.loadA ? bus.dinA : voteA_s;
      regB_r <= bus.loadB ? bus.dinB : voteB_s;
      regC_r <= bus.loadC ? bus.dinC : voteC_s;
    end
  end

  // Mismatch flags report the pre-edge state one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      errA_r     <= 1'b0;
      errB_r     <= 1'b0;
      errC_r     <= 1'b0;
      tmrErr_r   <= 1'b0;
      multiErr_r <= 1'b0;
    end else begin
      errA_r     <= mmA_s;
      errB_r     <= mmB_s;
      errC_r     <= mmC_s;
      tmrErr_r   <= anyMm_s;
      multiErr_r <= multiMm_s;
    end
  end

  // Per-channel saturating error counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cntA_r <= CNT_ZERO;
      cntB_r <= CNT_ZERO;
      cntC_r <= CNT_ZERO;
    end else begin
      cntA_r <= nextCnt(cntA_r, mmA_s, bus.clearCnt);
      cntB_r <= nextCnt(cntB_r, mmB_s, bus.clearCnt);
      cntC_r <= nextCnt(cntC_r, mmC_s, bus.clearCnt);
    end
  end

  assign bus.doutA    = voteA_s;
  assign bus.doutB    = voteB_s;
  assign bus.doutC    = voteC_s;
  assign bus.errA     = errA_r;
  assign bus.errB     = errB_r;
  assign bus.errC     = errC_r;
  assign bus.tmrErr   = tmrErr_r;
  assign bus.multiErr = multiErr_r;
  assign bus.errCntA  = cntA_r;
  assign bus.errCntB  = cntB_r;
  assign bus.errCntC  = cntC_r;

endmodule

// File: tb/tb_tmr_scrub_register.sv
// Bench for tmr_scrub_register: directed vector table, randomized run against a
// bit-counting reference model, and an asynchronous mid-load reset check.
module tb_tmr_scrub_register;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tmr_scrub_if #(.WIDTH(8), .CNT_WIDTH(8)) bus1 ();
  tmr_scrub_if #(.WIDTH(8), .CNT_WIDTH(2)) bus2 ();

  tmr_scrub_register #(.WIDTH(8), .CNT_WIDTH(8), .RESET_VALUE(8'h00)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1)
  );
  tmr_scrub_register #(.WIDTH(8), .CNT_WIDTH(2), .RESET_VALUE(8'h00)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: channel contents, flags, counters for both counter widths.
  logic [7:0] mr [3];
  logic [2:0] mErr;
  logic       mTmr;
  logic       mMulti;
  int         mCnt8 [3];
  int         mCnt2 [3];

  typedef struct {
    logic [7:0] dA, dB, dC;
    logic [2:0] ld;      // bit0 = A, bit1 = B, bit2 = C
    logic       clr;
    logic [7:0] eDout;
    logic [2:0] eErr;    // bit0 = A
    logic       eTmr, eMulti;
    logic [7:0] eCntA, eCntB, eCntC;
    logic [1:0] eCnt2B;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Majority by counting ones per bit position.
  function automatic logic [7:0] refVote(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      int ones;
      ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
      v[k] = (ones >= 2);
    end
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mr[i] = 8'h00; mCnt8[i] = 0; mCnt2[i] = 0;
    end
    mErr = 3'b000; mTmr = 1'b0; mMulti = 1'b0;
  endtask

  task automatic modelStep(input logic [7:0] dA, input logic [7:0] dB, input logic [7:0] dC,
                           input logic [2:0] ld, input logic clr);
    logic [7:0] v;
    logic [7:0] d [3];
    int nmm;
    d[0] = dA; d[1] = dB; d[2] = dC;
    v = refVote(mr[0], mr[1], mr[2]);
    nmm = 0;
    for (int i = 0; i < 3; i++) begin
      logic mm;
      mm = (mr[i] != v);
      mErr[i] = mm;
      nmm += int'(mm);
      if (clr) begin
        mCnt8[i] = 0; mCnt2[i] = 0;
      end else if (mm) begin
        if (mCnt8[i] < 255) mCnt8[i]++;
        if (mCnt2[i] < 3)   mCnt2[i]++;
      end
    end
    mTmr = (nmm > 0);
    mMulti = (nmm >= 2);
    for (int i = 0; i < 3; i++) mr[i] = ld[i] ? d[i] : v;
  endtask

  task automatic setIn(input logic [7:0] dA, input logic [7:0] dB, input logic [7:0] dC,
                       input logic [2:0] ld, input logic clr);
    bus1.dinA = dA; bus1.dinB = dB; bus1.dinC = dC;
    bus1.loadA = ld[0]; bus1.loadB = ld[1]; bus1.loadC = ld[2]; bus1.clearCnt = clr;
    bus2.dinA = dA; bus2.dinB = dB; bus2.dinC = dC;
    bus2.loadA = ld[0]; bus2.loadB = ld[1]; bus2.loadC = ld[2]; bus2.clearCnt = clr;
  endtask

  // Drive inputs, let one edge pass, advance the model, settle at edge+1.
  task automatic cycle(input logic [7:0] dA, input logic [7:0] dB, input logic [7:0] dC,
                       input logic [2:0] ld, input logic clr);
    setIn(dA, dB, dC, ld, clr);
    @(posedge clk);
    modelStep(dA, dB, dC, ld, clr);
    #1;
  endtask

  task automatic checkModel();
    logic [7:0] v;
    v = refVote(mr[0], mr[1], mr[2]);
    chk("m_doutA1", bus1.doutA, v);
    chk("m_doutB1", bus1.doutB, v);
    chk("m_doutC1", bus1.doutC, v);
    chk("m_doutA2", bus2.doutA, v);
    chk("m_err1", {bus1.errC, bus1.errB, bus1.errA}, mErr);
    chk("m_err2", {bus2.errC, bus2.errB, bus2.errA}, mErr);
    chk("m_tmr1", bus1.tmrErr, mTmr);
    chk("m_multi1", bus1.multiErr, mMulti);
    chk("m_multi2", bus2.multiErr, mMulti);
    chk("m_cnt8A", bus1.errCntA, mCnt8[0]);
    chk("m_cnt8B", bus1.errCntB, mCnt8[1]);
    chk("m_cnt8C", bus1.errCntC, mCnt8[2]);
    chk("m_cnt2A", bus2.errCntA, mCnt2[0]);
    chk("m_cnt2B", bus2.errCntB, mCnt2[1]);
    chk("m_cnt2C", bus2.errCntC, mCnt2[2]);
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_doutA"}, bus1.doutA, 8'h00);
    chk({tag, "_doutB"}, bus1.doutB, 8'h00);
    chk({tag, "_doutC"}, bus1.doutC, 8'h00);
    chk({tag, "_dout2"}, bus2.doutB, 8'h00);
    chk({tag, "_flags"}, {bus1.errC, bus1.errB, bus1.errA, bus1.tmrErr, bus1.multiErr}, 5'b00000);
    chk({tag, "_cnt"}, {bus1.errCntA, bus1.errCntB, bus1.errCntC}, 24'h000000);
    chk({tag, "_cnt2"}, {bus2.errCntA, bus2.errCntB, bus2.errCntC}, 6'b000000);
  endtask

  initial begin
    //             dA     dB     dC     ld      clr   dout   err     tmr   mul   cA     cB     cC     c2B
    vecs[0]  = '{8'hA5, 8'hA5, 8'hA5, 3'b111, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0};
    vecs[1]  = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0};
    vecs[2]  = '{8'h00, 8'h25, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd0, 8'd1, 8'd0, 2'd1};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 2'd1};
    vecs[5]  = '{8'hA4, 8'h00, 8'hAD, 3'b101, 1'b1, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b101, 1'b1, 1'b1, 8'd1, 8'd0, 8'd1, 2'd0};
    vecs[7]  = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd1, 8'd0, 8'd1, 2'd0};
    vecs[8]  = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd1, 8'd0, 8'd1, 2'd0};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd1, 8'd1, 8'd1, 2'd1};
    vecs[10] = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd1, 8'd2, 8'd1, 2'd2};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd1, 8'd3, 8'd1, 2'd3};
    vecs[12] = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd1, 8'd4, 8'd1, 2'd3};
    vecs[13] = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd1, 8'd5, 8'd1, 2'd3};
    vecs[14] = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b1, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0};
    vecs[15] = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b010, 1'b1, 1'b0, 8'd0, 8'd1, 8'd0, 2'd1};
    vecs[16] = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'hA5, 3'b000, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 2'd1};
    vecs[17] = '{8'h00, 8'h00, 8'h00, 3'b111, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 2'd1};
    vecs[18] = '{8'hFF, 8'h00, 8'h00, 3'b001, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 2'd1};
    vecs[19] = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 3'b001, 1'b1, 1'b0, 8'd1, 8'd1, 8'd0, 2'd1};
    vecs[20] = '{8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 2'd1};

    // Reset state
    rstn = 1'b0;
    setIn(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkZero("rst");
    rstn = 1'b1;

    // Directed table
    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].dA, vecs[i].dB, vecs[i].dC, vecs[i].ld, vecs[i].clr);
      chk($sformatf("v%0d_doutA", i), bus1.doutA, vecs[i].eDout);
      chk($sformatf("v%0d_doutB", i), bus1.doutB, vecs[i].eDout);
      chk($sformatf("v%0d_doutC", i), bus1.doutC, vecs[i].eDout);
      chk($sformatf("v%0d_err", i), {bus1.errC, bus1.errB, bus1.errA}, vecs[i].eErr);
      chk($sformatf("v%0d_tmr", i), bus1.tmrErr, vecs[i].eTmr);
      chk($sformatf("v%0d_multi", i), bus1.multiErr, vecs[i].eMulti);
      chk($sformatf("v%0d_cntA", i), bus1.errCntA, vecs[i].eCntA);
      chk($sformatf("v%0d_cntB", i), bus1.errCntB, vecs[i].eCntB);
      chk($sformatf("v%0d_cntC", i), bus1.errCntC, vecs[i].eCntC);
      chk($sformatf("v%0d_cnt2B", i), bus2.errCntB, vecs[i].eCnt2B);
      checkModel();
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a, b, c;
      logic [2:0] ld;
      logic clr;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      ld = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        b = a; c = a; ld = 3'b111;
      end else if ($urandom_range(0, 2) == 0) begin
        ld = 3'b000;
      end
      clr = ($urandom_range(0, 15) == 0);
      cycle(a, b, c, ld, clr);
      checkModel();
    end

    // Asynchronous reset mid-cycle while loads are active
    cycle(8'h5A, 8'h5A, 8'h5A, 3'b111, 1'b0);
    cycle(8'h5A, 8'h3C, 8'h5A, 3'b010, 1'b0);
    checkModel();
    #3;
    rstn = 1'b0;
    #1;
    checkZero("arst");
    modelReset();
    @(posedge clk);
    #1;
    checkZero("arst_hold");
    setIn(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    rstn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      checkModel();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
